// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding,
// source-count limit and the index-width helper.
package uart_pkg;

    localparam int unsigned MAX_SRC = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } arb_state_e;

    // Width of a source index; never narrower than one bit.
    function automatic int unsigned idw(input int unsigned n);
        return (n <= 2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Bundle of source-side and serializer-side signals of uart_tx_arb.
// master: the arbiter itself; slave: sources, serializer and status consumer.
interface uart_tx_arb_if #(
    parameter int unsigned NUM_SRC = 4
);
    localparam int unsigned IDW = uart_pkg::idw(NUM_SRC);

    logic [NUM_SRC-1:0]   src_valid;
    logic [NUM_SRC*8-1:0] src_data;
    logic [NUM_SRC-1:0]   src_last;
    logic [NUM_SRC-1:0]   src_ready;
    logic                 tx_busy;
    logic                 tx_req;
    logic [7:0]           tx_byte;
    logic [IDW-1:0]       grant_id;
    logic                 active;
    logic                 err_clr;
    logic                 timeout_err;

    modport master (
        input  src_valid, src_data, src_last, tx_busy, err_clr,
        output src_ready, tx_req, tx_byte, grant_id, active, timeout_err
    );

    modport slave (
        output src_valid, src_data, src_last, tx_busy, err_clr,
        input  src_ready, tx_req, tx_byte, grant_id, active, timeout_err
    );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin select. Returns the first eligible
// requester at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   mask,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx,
    output logic           any
);

    logic [N-1:0] elig;
    logic [N-1:0] rot;

    // Rotate so bit 0 is the source at ptr, then take the first set bit.
    always_comb begin
        elig = req & mask;
        rot  = (elig >> ptr) | (elig << (N - 32'(ptr)));
        any  = 1'b0;
        idx  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                idx = IDW'((32'(ptr) + i) % N);
            end
        end
        gnt = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one uart_tx serializer between NUM_SRC byte sources.
// Round-robin grant, one byte per accept, req/busy handshake to the
// serializer with a request timeout and sticky error flag.
// Optional frame lock (keeps the grant until src_last) when the macro
// UART_ARB_LOCK_EN is defined; default build arbitrates every byte.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned REQ_TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_arb_if.master bus
);

    localparam int unsigned     IDW     = idw(NUM_SRC);
    localparam int unsigned     CNTW    = 16;
    localparam logic [CNTW-1:0] TO_LAST = CNTW'(REQ_TIMEOUT - 1);

    arb_state_e         state_q, state_d;
    logic               tx_req_q, tx_req_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic               active_q, active_d;
    logic               timeout_err_q, timeout_err_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;

    logic [NUM_SRC-1:0] elig_mask;
    logic [NUM_SRC-1:0] pick_gnt;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic [NUM_SRC-1:0] src_ready_c;
    logic               accept;
    logic               timeout_hit;

`ifdef UART_ARB_LOCK_EN
    logic lock_q, lock_d;
    logic last_sel;

    // While a frame is open only its owner may be granted.
    always_comb begin
        elig_mask = lock_q ? (NUM_SRC'(1) << grant_id_q) : '1;
        last_sel  = |(bus.src_last & pick_gnt);
    end

    // Lock opens on a non-final byte, closes on the final byte or a timeout.
    always_comb begin
        lock_d = lock_q;
        if (accept) begin
            lock_d = !last_sel;
        end else if (timeout_hit) begin
            lock_d = 1'b0;
        end
    end

    // Frame lock register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    logic unused_src_last;

    assign elig_mask       = '1;
    assign unused_src_last = ^bus.src_last;
`endif

    rr_pick #(
        .N   (NUM_SRC),
        .IDW (IDW)
    ) u_pick (
        .req  (bus.src_valid),
        .mask (elig_mask),
        .ptr  (rr_ptr_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Next state, accept strobe, timeout counter and output register inputs.
    always_comb begin
        state_d     = state_q;
        tx_byte_d   = tx_byte_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = '0;
        timeout_hit = 1'b0;
        accept      = 1'b0;
        src_ready_c = '0;

        case (state_q)
            S_IDLE: begin
                if (rst_n && !bus.tx_busy && pick_any) begin
                    accept      = 1'b1;
                    src_ready_c = pick_gnt;
                    tx_byte_d   = 8'(bus.src_data >> {pick_idx, 3'b000});
                    grant_id_d  = pick_idx;
`ifdef UART_ARB_LOCK_EN
                    if (!lock_q) begin
                        rr_ptr_d = (32'(pick_idx) == NUM_SRC - 1) ? '0 : pick_idx + IDW'(1);
                    end
`else
                    rr_ptr_d = (32'(pick_idx) == NUM_SRC - 1) ? '0 : pick_idx + IDW'(1);
`endif
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.tx_busy) begin
                    state_d = S_DRAIN;
                end else if (cnt_q == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_DRAIN: begin
                if (!bus.tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        tx_req_d      = (state_d == S_REQ);
        active_d      = (state_d != S_IDLE);
        timeout_err_d = timeout_hit ? 1'b1 : (bus.err_clr ? 1'b0 : timeout_err_q);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            tx_req_q      <= 1'b0;
            tx_byte_q     <= 8'h00;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
            active_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            tx_req_q      <= tx_req_d;
            tx_byte_q     <= tx_byte_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            active_q      <= active_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.src_ready   = src_ready_c;
    assign bus.tx_req      = tx_req_q;
    assign bus.tx_byte     = tx_byte_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.active      = active_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: per-source byte queues, a small uart_tx busy model
// and a cycle reference model of the arbitration rules.
module tb_uart_tx_arb;

    localparam int NSRC = 4;
    localparam int TO   = 16;

    logic clk;
    logic rst_n;

    uart_tx_arb_if #(.NUM_SRC(NSRC)) bus ();

    uart_tx_arb #(
        .NUM_SRC     (NSRC),
        .REQ_TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // pending bytes per source: bit 8 = last marker
    logic [8:0] srcq [NSRC][$];

    // serializer model controls
    bit   ser_on;
    int   ser_delay;
    int   ser_hold;
    int   ser_cnt;
    bit   ser_busy;
    bit   force_v;
    bit   clr_v;
    bit   rst_v;
    bit   gate_en;
    logic [7:0] sent_b [$];

    // reference model: phase 0 = waiting for a source, 1 = offering byte, 2 = serializer busy
    int   m_phase;
    int   m_ptr;
    int   m_gid;
    int   m_cnt;
    logic [7:0] m_byte;
    bit   m_err;
    bit   m_lock;
    int   grants [$];
    int   pulses [NSRC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_ptr   = 0;
        m_gid   = 0;
        m_cnt   = 0;
        m_byte  = 8'h00;
        m_err   = 1'b0;
        m_lock  = 1'b0;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NSRC; i++) begin
            if (srcq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive();
        logic [8:0] e;
        rst_n       = rst_v;
        bus.err_clr = clr_v;
        for (int i = 0; i < NSRC; i++) begin
            if (srcq[i].size() > 0 && !(gate_en && ($urandom_range(0, 3) == 0))) begin
                e = srcq[i][0];
                bus.src_valid[i]       = 1'b1;
                bus.src_data[8*i +: 8] = e[7:0];
                bus.src_last[i]        = e[8];
            end else begin
                bus.src_valid[i]       = 1'b0;
                bus.src_data[8*i +: 8] = 8'($urandom);
                bus.src_last[i]        = 1'($urandom);
            end
        end
    endtask

    task automatic ser_step();
        if (!rst_n) begin
            ser_busy = 1'b0;
            ser_cnt  = 0;
        end else if (ser_busy) begin
            ser_cnt++;
            if (ser_cnt >= ser_hold) begin
                ser_busy = 1'b0;
                ser_cnt  = 0;
            end
        end else if (bus.tx_req && ser_on) begin
            ser_cnt++;
            if (ser_cnt >= ser_delay) begin
                ser_busy = 1'b1;
                ser_cnt  = 0;
                sent_b.push_back(bus.tx_byte);
            end
        end else begin
            ser_cnt = 0;
        end
        bus.tx_busy = ser_busy | force_v;
    endtask

    task automatic step_model();
        int w;
        int j;
        int exp_ready;
        logic [NSRC-1:0] elig;
        logic [8:0] e;
        bit set_err;
        if (!rst_n) model_reset();
        w = -1;
        if (rst_n && m_phase == 0 && !bus.tx_busy) begin
            elig = m_lock ? (NSRC'(1) << m_gid) : '1;
            for (int k = 0; k < NSRC; k++) begin
                j = (m_ptr + k) % NSRC;
                if (w < 0 && bus.src_valid[j] && elig[j]) w = j;
            end
        end
        exp_ready = (w >= 0) ? (1 << w) : 0;
        chk("src_ready", 32'(bus.src_ready), exp_ready);
        chk("tx_req", 32'(bus.tx_req), (m_phase == 1) ? 1 : 0);
        chk("active", 32'(bus.active), (m_phase != 0) ? 1 : 0);
        chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
        chk("grant_id", 32'(bus.grant_id), m_gid);
        chk("tx_byte", 32'(bus.tx_byte), 32'(m_byte));
        if (!rst_n) return;
        set_err = 1'b0;
        if (m_phase == 0) begin
            if (w >= 0) begin
                e = srcq[w].pop_front();
                grants.push_back(w);
                pulses[w]++;
                m_byte = e[7:0];
                m_gid  = w;
`ifdef UART_ARB_LOCK_EN
                if (!m_lock) m_ptr = (w + 1) % NSRC;
                m_lock = !e[8];
`else
                m_ptr = (w + 1) % NSRC;
`endif
                m_phase = 1;
                m_cnt   = 0;
            end
        end else if (m_phase == 1) begin
            m_cnt++;
            if (bus.tx_busy) begin
                m_phase = 2;
            end else if (m_cnt == TO) begin
                set_err = 1'b1;
                m_phase = 0;
                m_lock  = 1'b0;
            end
        end else begin
            if (!bus.tx_busy) m_phase = 0;
        end
        m_err = set_err ? 1'b1 : (bus.err_clr ? 1'b0 : m_err);
    endtask

    task automatic tick();
        @(negedge clk);
        drive();
        ser_step();
        #1;
        step_model();
    endtask

    task automatic do_reset();
        rst_v    = 1'b0;
        rst_n    = 1'b0;
        ser_busy = 1'b0;
        ser_cnt  = 0;
        model_reset();
        repeat (3) tick();
        rst_v = 1'b1;
        tick();
    endtask

    task automatic run_until_quiet(input int budget, input string tag);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = all_empty() && (m_phase == 0) && !ser_busy;
        end
        chk(tag, 32'(done), 1);
        repeat (2) tick();
    endtask

    initial begin
        int   reqc;
        int   len;
        int   s;
        bit   prev_req;
        logic err_at_fall;
        int   exp_lock [4];

        checks = 0;
        errors = 0;
        rst_v = 1'b0; rst_n = 1'b0; clr_v = 1'b0; force_v = 1'b0; gate_en = 1'b0;
        ser_on = 1'b1; ser_delay = 3; ser_hold = 10; ser_busy = 1'b0; ser_cnt = 0;
        bus.tx_busy = 1'b0; bus.src_valid = '0; bus.src_data = '0; bus.src_last = '0; bus.err_clr = 1'b0;
        for (int i = 0; i < NSRC; i++) pulses[i] = 0;
        model_reset();

        // reset values
        do_reset();

        // single source, busy 3 cycles after req, held 10
        sent_b.delete();
        srcq[2].push_back({1'b1, 8'hA5});
        run_until_quiet(200, "single_done");
        chk("single_sent_cnt", 32'(sent_b.size()), 1);
        chk("single_byte", 32'(sent_b[0]), 32'h0000_00A5);
        chk("single_pulses", 32'(pulses[2]), 1);
        chk("single_grant", 32'(bus.grant_id), 2);

        // fairness: all sources continuously valid
        do_reset();
        ser_delay = 1; ser_hold = 2;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < NSRC; i++) srcq[i].push_back({1'b1, 8'($urandom)});
        grants.delete();
        run_until_quiet(600, "fair_done");
        chk("fair_count", 32'(grants.size()), 12);
        for (int n = 0; n < 12; n++) chk("fair_order", 32'(grants[n]), n % NSRC);

        // randomized traffic with valid gaps, frames of 1..3 bytes
        gate_en = 1'b1;
        for (int round = 0; round < 5; round++) begin
            ser_delay = $urandom_range(1, 5);
            ser_hold  = $urandom_range(1, 6);
            for (int f = 0; f < int'($urandom_range(3, 8)); f++) begin
                s   = $urandom_range(0, NSRC - 1);
                len = $urandom_range(1, 3);
                for (int b = 0; b < len; b++) srcq[s].push_back({b == len - 1, 8'($urandom)});
            end
            run_until_quiet(3000, "rand_done");
        end
        gate_en = 1'b0;

        // timeout: serializer never answers
        do_reset();
        ser_on = 1'b0;
        srcq[1].push_back({1'b1, 8'h3C});
        reqc = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (bus.tx_req) reqc++;
        end
        chk("to_req_cycles", 32'(reqc), TO);
        chk("to_err", 32'(bus.timeout_err), 1);
        chk("to_active", 32'(bus.active), 0);
        clr_v = 1'b1;
        tick();
        clr_v = 1'b0;
        tick();
        chk("to_clr", 32'(bus.timeout_err), 0);

        // timeout while err_clr held: set wins on that edge
        srcq[1].push_back({1'b1, 8'hC3});
        clr_v = 1'b1;
        prev_req = 1'b0;
        err_at_fall = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (prev_req && !bus.tx_req) err_at_fall = bus.timeout_err;
            prev_req = bus.tx_req;
        end
        chk("to_set_wins", 32'(err_at_fall), 1);
        chk("to_clr_after", 32'(bus.timeout_err), 0);
        clr_v  = 1'b0;
        ser_on = 1'b1;

        // busy at idle blocks accept
        do_reset();
        ser_delay = 2; ser_hold = 3;
        force_v = 1'b1;
        srcq[1].push_back({1'b1, 8'h5A});
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("bidle_ready", 32'(bus.src_ready), 0);
        end
        force_v = 1'b0;
        tick();
        chk("bidle_accept", 32'(bus.src_ready), 32'h2);
        run_until_quiet(200, "bidle_done");

        // frame of three bytes from source 0 while source 1 waits
        do_reset();
        srcq[0].push_back({1'b0, 8'h11});
        srcq[0].push_back({1'b0, 8'h22});
        srcq[0].push_back({1'b1, 8'h33});
        srcq[1].push_back({1'b1, 8'h44});
        grants.delete();
        run_until_quiet(300, "lock_done");
`ifdef UART_ARB_LOCK_EN
        exp_lock = '{0, 0, 0, 1};
`else
        exp_lock = '{0, 1, 0, 0};
`endif
        for (int n = 0; n < 4; n++) chk("lock_order", 32'(grants[n]), exp_lock[n]);

        // asynchronous reset during S_REQ
        do_reset();
        ser_delay = 8;
        srcq[2].push_back({1'b1, 8'h77});
        for (int n = 0; n < 20 && !bus.tx_req; n++) tick();
        chk("mid_req_seen", 32'(bus.tx_req), 1);
        rst_v = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_tx_req", 32'(bus.tx_req), 0);
        chk("mid_active", 32'(bus.active), 0);
        chk("mid_grant", 32'(bus.grant_id), 0);
        chk("mid_byte", 32'(bus.tx_byte), 0);
        model_reset();
        ser_busy = 1'b0;
        ser_cnt  = 0;
        repeat (2) tick();
        rst_v = 1'b1;
        ser_delay = 2;
        srcq[0].push_back({1'b1, 8'h88});
        srcq[3].push_back({1'b1, 8'h99});
        grants.delete();
        run_until_quiet(200, "mid_done");
        chk("mid_next_grant", 32'(grants[0]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
